fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 Parameter FQ_DEPTH, default 2, SHALL set the fetch-queue depth in entries (legal: 2, 4).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 Resetn  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 imem_pc  out  32  word address driven to the combinational instruction memory.
REQ-006 imem_instr  in  32  instruction returned combinationally for imem_pc in the same cycle.
REQ-007 redirect_valid  in  1  branch/jump redirect request, single-cycle pulse.
REQ-008 redirect_pc  in  32  redirect target; bits [1:0] ignored.
REQ-009 halt_req  in  1  stop issuing new fetches.
REQ-010 resume  in  1  restart fetching from HALT.
REQ-011 out_valid  out  1  queue head valid toward decode.
REQ-012 out_ready  in  1  decode accepts the head.
REQ-013 out_pc  out  32  PC of the head instruction.
REQ-014 out_instr  out  32  head instruction word.
REQ-015 halted  out  1  high while in HALT.

Function
REQ-016 States SHALL be IDLE, RUN, HALT; IDLE lasts exactly one cycle after reset release, then RUN.
REQ-017 imem_pc SHALL equal fetch_pc combinationally in every state.
REQ-018 In RUN, a push of {fetch_pc, imem_instr} SHALL occur on a rising edge when count < FQ_DEPTH, or count == FQ_DEPTH with a pop in the same cycle; each push advances fetch_pc by 4, modulo 2^32.
REQ-019 No push SHALL occur in IDLE or HALT; fetch_pc holds.
REQ-020 out_valid SHALL equal (count != 0); out_pc and out_instr SHALL show the head entry and SHALL be 0 when empty.
REQ-021 Pop SHALL occur when out_valid && out_ready; push and pop in one cycle leave count unchanged.
REQ-022 First out_valid after reset SHALL rise 2 cycles after reset release (IDLE cycle, push edge), with out_pc = RESET_PC.
REQ-023 Redirect has highest priority: on redirect_valid the queue SHALL be flushed (count=0, no push that edge) and fetch_pc <= {redirect_pc[31:2], 2'b00}.
REQ-024 A head accepted in the redirect cycle counts as consumed; decode owns squashing it.
REQ-025 After redirect in RUN, out_valid SHALL be low for exactly one cycle, then present the target with out_pc = target.
REQ-026 halt_req in RUN SHALL enter HALT at the next edge; a push on that same edge still occurs if allowed; the queue keeps draining in HALT.
REQ-027 resume in HALT SHALL enter RUN at the next edge; resume outside HALT SHALL be ignored; if halt_req and resume are both high in HALT, it stays HALT.
REQ-028 Redirect in HALT SHALL update fetch_pc and flush; state stays HALT.
REQ-029 Redirect with halt_req in RUN SHALL both apply: flush, new fetch_pc, enter HALT.
REQ-030 Queue pointers SHALL wrap modulo FQ_DEPTH; no overflow or underflow SHALL be possible.

Reset
REQ-031 While Resetn is low at an edge: state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0, out_valid=0, out_pc=0, out_instr=0, halted=0.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries and pending redirect/halt within that edge.

Structure
REQ-033 A shared package SHALL hold the state enum (IDLE/RUN/HALT), INSTR_BYTES=4, and the default RESET_PC.
REQ-034 The queue SHALL be a sub-module fetch_fifo (parameterised depth, 64-bit entries, flush input); fetch_ctrl holds the FSM and fetch_pc.

Verification
REQ-035 Reset release, out_ready=1 -> out_valid at cycle 2, out_pc 0,4,8,12 on consecutive cycles.
REQ-036 out_ready=0 for 5 cycles -> count saturates at 2, fetch_pc stops at 8, out_pc holds 0; release -> 0,4,8 with no gaps or duplicates.
REQ-037 redirect_valid with redirect_pc=32'h0000_0033 while full -> one bubble, next out_pc=32'h30, stale entries never appear.
REQ-038 halt_req at out_pc=8 -> halted=1, queue drains, no new pc; resume -> fetch continues from the held fetch_pc.
REQ-039 Simultaneous redirect (target 32'h40) and halt_req -> out_valid low, halted=1; resume -> out_pc=32'h40.
REQ-040 Resetn low for one cycle mid-stream with a full queue -> all outputs 0, restart from RESET_PC after 2 cycles.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller and its queue.
// Queue entries pack {pc, instr} into one 64-bit word.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle: combinational imem port, redirect/halt control, decode handshake.
// master = fetch controller, slave = surrounding core (imem, branch unit, decode).
interface fetch_ctrl_if;

  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        resume;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        halted;

  modport master (
    output imem_pc, out_valid, out_pc, out_instr, halted,
    input  imem_instr, redirect_valid, redirect_pc, halt_req, resume, out_ready
  );

  modport slave (
    input  imem_pc, out_valid, out_pc, out_instr, halted,
    output imem_instr, redirect_valid, redirect_pc, halt_req, resume, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Fetch queue, DEPTH entries (power of two), head visible combinationally; flush wins over push/pop.
// Push into a full queue is accepted only when the head is popped on the same edge.
module fetch_fifo
  import fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      Resetn,
  input  logic      flush,
  input  logic      push,
  input  fq_entry_t push_dat,
  input  logic      pop,
  output fq_entry_t head_dat,
  output logic      head_vld,
  output logic      full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fq_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign head_vld = (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && head_vld && !flush;
  assign do_push  = push && !flush && (!full || do_pop);
  assign head_dat = head_vld ? mem[rd_ptr] : '0;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!Resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch FSM: first head 2 cycles after reset release, redirect costs one bubble.
// Fetching stalls while the queue is full and decode holds out_ready low.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          FQ_DEPTH = 2
) (
  input  logic          clk,
  input  logic          Resetn,
  fetch_ctrl_if.master  bus
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_nxt;
  logic        push;
  logic        pop;
  logic        fq_full;
  logic        fq_vld;
  fq_entry_t   fq_head;
  fq_entry_t   fq_in;

  assign pop         = fq_vld && bus.out_ready;
  assign fq_in       = '{pc: fetch_pc, instr: bus.imem_instr};
  assign bus.imem_pc = fetch_pc;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    push         = 1'b0;
    case (state)
      IDLE: state_nxt = RUN;
      RUN: begin
        push = !bus.redirect_valid && (!fq_full || pop);
        if (bus.halt_req) state_nxt = HALT;
      end
      HALT: if (bus.resume && !bus.halt_req) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    // Redirect overrides sequential advance; the flush drops anything queued.
    if (bus.redirect_valid)
      fetch_pc_nxt = {bus.redirect_pc[31:2], 2'b00};
    else if (push)
      fetch_pc_nxt = fetch_pc + 32'(INSTR_BYTES);
  end

  always_ff @(posedge clk) begin
    if (!Resetn) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fifo (
    .clk      (clk),
    .Resetn   (Resetn),
    .flush    (bus.redirect_valid),
    .push     (push),
    .push_dat (fq_in),
    .pop      (pop),
    .head_dat (fq_head),
    .head_vld (fq_vld),
    .full     (fq_full)
  );

  assign bus.out_valid = fq_vld;
  assign bus.out_pc    = fq_head.pc;
  assign bus.out_instr = fq_head.instr;
  assign bus.halted    = (state == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: stimulus queues expected PCs, a negedge monitor checks each accepted head.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge or right after driving.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic Resetn;

  fetch_ctrl_if bus();

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(2)) dut (
    .clk    (clk),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return ~pc ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_instr = instr_of(bus.imem_pc);

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back(pc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    repeat (2) tick();
    Resetn = 1'b1;
  endtask

  // Scoreboard monitor: every head accepted by decode must be the next expected PC.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_head: got pc %h expected none", bus.out_pc);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("mon_pc", bus.out_pc, mon_exp);
        chk("mon_instr", bus.out_instr, instr_of(mon_exp));
      end
    end
  end

  initial begin
    Resetn             = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.halt_req       = 1'b0;
    bus.resume         = 1'b0;
    bus.out_ready      = 1'b1;

    // Reset state, then streaming with decode always ready.
    repeat (2) tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_pc", bus.out_pc, 32'h0);
    chk("rst_instr", bus.out_instr, 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_imem_pc", bus.imem_pc, 32'h0);
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    Resetn = 1'b1;
    tick();
    chk("idle_no_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("first_valid", 32'(bus.out_valid), 32'd1);
    chk("first_pc", bus.out_pc, 32'h0);
    repeat (4) tick();
    bus.out_ready = 1'b0;

    // Backpressure: queue saturates at two entries.
    do_reset();
    repeat (5) tick();
    chk("stall_valid", 32'(bus.out_valid), 32'd1);
    chk("stall_pc", bus.out_pc, 32'h0);
    chk("stall_fetch_pc", bus.imem_pc, 32'h8);
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    bus.out_ready = 1'b1;
    repeat (4) tick();
    bus.out_ready = 1'b0;
    chk("full_fetch_pc", bus.imem_pc, 32'h18);

    // Redirect while full: one bubble, low address bits dropped, stale entries flushed.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0033;
    tick();
    bus.redirect_valid = 1'b0;
    chk("redir_bubble", 32'(bus.out_valid), 32'd0);
    chk("redir_fetch_pc", bus.imem_pc, 32'h30);
    expect_pc(32'h30); expect_pc(32'h34);
    bus.out_ready = 1'b1;
    tick();
    chk("redir_target", bus.out_pc, 32'h30);
    repeat (2) tick();
    bus.out_ready = 1'b0;

    // Halt at out_pc=8, drain, then resume from the held fetch_pc.
    do_reset();
    bus.out_ready = 1'b1;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    repeat (4) tick();
    chk("pre_halt_pc", bus.out_pc, 32'h8);
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    chk("halted", 32'(bus.halted), 32'd1);
    chk("halt_drain_pc", bus.out_pc, 32'hC);
    tick();
    chk("halt_empty", 32'(bus.out_valid), 32'd0);
    repeat (2) tick();
    chk("halt_still_empty", 32'(bus.out_valid), 32'd0);
    chk("halt_hold_fetch_pc", bus.imem_pc, 32'h10);
    expect_pc(32'h10); expect_pc(32'h14);
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    chk("resumed", 32'(bus.halted), 32'd0);
    tick();
    chk("resume_pc", bus.out_pc, 32'h10);
    repeat (2) tick();
    bus.out_ready = 1'b0;

    // Redirect and halt together; halt_req+resume both high keeps HALT.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0040;
    bus.halt_req       = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    chk("rh_valid", 32'(bus.out_valid), 32'd0);
    chk("rh_halted", 32'(bus.halted), 32'd1);
    bus.resume = 1'b1;
    tick();
    chk("rh_both_high", 32'(bus.halted), 32'd1);
    bus.halt_req = 1'b0;
    tick();
    bus.resume = 1'b0;
    chk("rh_resumed", 32'(bus.halted), 32'd0);
    chk("rh_empty", 32'(bus.out_valid), 32'd0);
    expect_pc(32'h40); expect_pc(32'h44);
    bus.out_ready = 1'b1;
    tick();
    chk("rh_target", bus.out_pc, 32'h40);
    repeat (2) tick();
    bus.out_ready = 1'b0;

    // One-cycle reset with a full queue, then restart from RESET_PC.
    repeat (2) tick();
    chk("prefill_valid", 32'(bus.out_valid), 32'd1);
    chk("prefill_pc", bus.out_pc, 32'h48);
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_pc", bus.out_pc, 32'h0);
    chk("mid_rst_instr", bus.out_instr, 32'h0);
    chk("mid_rst_halted", 32'(bus.halted), 32'd0);
    chk("mid_rst_imem_pc", bus.imem_pc, 32'h0);
    expect_pc(32'h0); expect_pc(32'h4);
    bus.out_ready = 1'b1;
    tick();
    chk("mid_rst_idle", 32'(bus.out_valid), 32'd0);
    tick();
    chk("mid_rst_restart_pc", bus.out_pc, 32'h0);
    repeat (2) tick();
    bus.out_ready = 1'b0;

    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
